sram_mem_controller: RTL and testbench

// - MEM-stage sequencer between the EXE/MEM pipeline register and a 16-bit asynchronous SRAM.
// - Splits each 32-bit load/store into two half-word SRAM transfers, each stretched by programmable wait states.
// - Holds ready low so the upstream pipeline freezes while an access is in flight.

---
 rtl/sram_mem_controller.sv | 128 ++++++++++++
 tb/tb_sram_mem_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// MEM-stage sequencer: splits 32-bit loads/stores into two wait-stated 16-bit SRAM transfers.
// Define SRAM_WRITE_BUFFER_EN for a one-entry posted write buffer (writes release the pipeline at once).
module sram_mem_controller #(
  parameter int          WAIT_CYCLES = 1,
  parameter int          ADDR_W      = 18,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_ce_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [4:0] LAST_CNT = 5'(WAIT_CYCLES);

  state_t            state, state_nx;
  logic [4:0]        cnt;
  logic              is_wr;
  logic [ADDR_W-2:0] word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       offs;
  logic              req;
  logic              last;
  logic              unused_offs_bits;

  assign req              = mem_read | mem_write;
  assign last             = (cnt == LAST_CNT);
  assign offs             = addr - BASE_ADDR;
  assign unused_offs_bits = ^{offs[31:ADDR_W+1], offs[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (state != state_nx) cnt <= '0;
    else if (cnt != '1)         cnt <= cnt + 5'd1;
  end

  // The request is captured on acceptance so a posted write survives the pipeline moving on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      is_wr   <= mem_write;
      word_q  <= offs[ADDR_W:2];
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (!is_wr && last) begin
      if (state == LO) rdata[15:0]  <= sram_dq_in;
      if (state == HI) rdata[31:16] <= sram_dq_in;
    end
  end

  // SRAM strobes decode straight from the state register so reset deasserts them without a clock.
  always_comb begin
    state_nx    = state;
    ready       = 1'b0;
    sram_ce_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    case (state)
      IDLE: begin
`ifdef SRAM_WRITE_BUFFER_EN
        ready = !req || mem_write;
`else
        ready = !req;
`endif
        if (req) state_nx = LO;
      end
      LO: begin
        sram_ce_n = 1'b0;
        sram_addr = {word_q, 1'b0};
        if (is_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
          sram_we_n   = last;
        end
        if (last) state_nx = HI;
      end
      HI: begin
        sram_ce_n = 1'b0;
        sram_addr = {word_q, 1'b1};
        if (is_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
          sram_we_n   = last;
        end
        if (last) begin
`ifdef SRAM_WRITE_BUFFER_EN
          state_nx = is_wr ? IDLE : DONE;
`else
          state_nx = DONE;
`endif
        end
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller with a behavioural 16-bit SRAM and a word-level memory model.
// Covers the posted write buffer build when SRAM_WRITE_BUFFER_EN is defined.
module tb_sram_mem_controller;

  localparam int WAIT = 1;
  localparam int LAT  = 2 * WAIT + 3;
`ifdef SRAM_WRITE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_ce_n;

  int checks   = 0;
  int failures = 0;

  sram_mem_controller #(.WAIT_CYCLES(WAIT), .ADDR_W(18), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: write lands while we_n is low, read is combinational.
  logic [15:0] sram [0:(1<<18)-1];
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
  assign sram_dq_in = (!sram_ce_n && sram_we_n && !sram_dq_oe) ? sram[sram_addr] : 16'h0;

  // First address presented in each access.
  logic        prev_ce_n = 1'b1;
  logic [31:0] lo_addr   = '0;
  int          lo_cnt    = 0;
  always @(negedge clk) begin
    if (!sram_ce_n && prev_ce_n) begin
      lo_addr = 32'(sram_addr);
      lo_cnt  = lo_cnt + 1;
    end
    prev_ce_n = sram_ce_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    mem_read = rd; mem_write = wr; addr = a; wdata = d; lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin lat = c; break; end
      step();
    end
    step();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl [11];
  logic [31:0] refm [int unsigned];
  logic [31:0] cur_rdata;

  initial begin
    int lat, lo0;
    logic [17:0] e_addr [6];
    logic [15:0] e_dq   [6];
    logic        e_we   [6];
    logic        e_ce   [6];
    logic        e_oe   [6];

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0004};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0408, 32'h0,         32'hDEAD_BEEF, 32'h0000_0004};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_040C, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0006};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_040C, 32'h0,         32'h1234_5678, 32'h0000_0006};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h1234_5678, 32'h0003_FFFE};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 32'h0003_FFFE};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0001_0002, 32'hCAFE_F00D, 32'h0000_0000};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0500, 32'h0,         32'h0000_0000, 32'h0000_0080};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h0001_0002, 32'h0000_0000};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_040B, 32'h0,         32'hDEAD_BEEF, 32'h0000_0004};
    tbl[10] = '{1'b1, 1'b0, 32'h0008_0400, 32'h0,         32'h0001_0002, 32'h0000_0000};

    e_addr = '{18'h0, 18'h4, 18'h4, 18'h5, 18'h5, 18'h0};
    e_dq   = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0};
    e_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    e_ce   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    e_oe   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state before any clock edge
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ce_n",  32'(sram_ce_n), 32'd1);
    chk("rst_we_n",  32'(sram_we_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr",  32'(sram_addr), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Cycle-by-cycle store waveform
    mem_write = 1'b1; addr = 32'h408; wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("st_ready_c%0d", c), 32'(ready), 32'((c == LAT) || (BUF && c == 0)));
      chk($sformatf("st_addr_c%0d", c),  32'(sram_addr), 32'(e_addr[c]));
      chk($sformatf("st_dq_c%0d", c),    32'(sram_dq_out), 32'(e_dq[c]));
      chk($sformatf("st_we_n_c%0d", c),  32'(sram_we_n), 32'(e_we[c]));
      chk($sformatf("st_ce_n_c%0d", c),  32'(sram_ce_n), 32'(e_ce[c]));
      chk($sformatf("st_oe_c%0d", c),    32'(sram_dq_oe), 32'(e_oe[c]));
      step();
      if (BUF || c == LAT) mem_write = 1'b0;
    end
    step();

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      lo0 = lo_cnt;
      access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), (tbl[i].wr && BUF) ? 32'd0 : 32'(LAT));
      if (BUF) repeat (5) step();
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_lo_addr", i), lo_addr, tbl[i].exp_lo);
      chk($sformatf("tbl%0d_lo_cnt", i), 32'(lo_cnt - lo0), 32'd1);
    end

    // Reset during the HI phase of a store
    mem_write = 1'b1; addr = 32'h410; wdata = 32'h55AA_1234;
    repeat (3) step();
    @(negedge clk);
    chk("hi_ce_n_before", 32'(sram_ce_n), 32'd0);
    chk("hi_addr_before", 32'(sram_addr), 32'h9);
    rst = 1'b1; mem_write = 1'b0;
    #1;
    chk("midrst_we_n",  32'(sram_we_n), 32'd1);
    chk("midrst_ce_n",  32'(sram_ce_n), 32'd1);
    chk("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_ready", 32'(ready), 32'd1);
    chk("postrst_rdata", rdata, 32'd0);
    step();
    cur_rdata = '0;

`ifdef SRAM_WRITE_BUFFER_EN
    // Posted store followed immediately by a load of the same word
    mem_write = 1'b1; addr = 32'h420; wdata = 32'hA5A5_5A5A;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("wb_ready_c%0d", c), 32'(ready), 32'(c == 0 || c == 10));
      if (c == 10) chk("wb_raw_rdata", rdata, 32'hA5A5_5A5A);
      step();
      if (c == 0) begin mem_write = 1'b0; mem_read = 1'b1; end
    end
    mem_read = 1'b0;
    cur_rdata = 32'hA5A5_5A5A;
    step();
`endif

    // Randomized traffic against a word-level memory model
    for (int n = 0; n < 40; n++) begin
      int unsigned kind, w;
      logic [31:0] a, d, exp;
      logic rd, wr;
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      a  = 32'h800 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      d  = $urandom;
      w  = (a - 32'd1024) >> 2;
      if (wr) refm[w] = d;
      else    cur_rdata = refm.exists(w) ? refm[w] : 32'h0;
      exp = cur_rdata;
      access(rd, wr, a, d, lat);
      chk($sformatf("rnd%0d_lat", n), 32'(lat), (wr && BUF) ? 32'd0 : 32'(LAT));
      if (BUF) repeat (5) step();
      else     repeat ($urandom_range(0, 1)) step();
      chk($sformatf("rnd%0d_rdata", n), rdata, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
